y86_imem_loader: RTL
====================

# y86_imem_loader

Program loader and instruction memory that sits directly upstream of the Y86 pipeline's fetch stage. Accepts a length-prefixed, checksummed program as a byte stream, writes it into a byte-addressed instruction store, and holds the pipeline in reset until a load completes cleanly. Once running, it serves a combinational 10-byte instruction window at the fetch PC, along with the fetch-side address error.

## Interface
- MEM_BYTES, 256: instruction store size in bytes; power of two, max 256.
- ADDR_W, 8: log2(MEM_BYTES).

- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  program stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; transfer = in_valid && in_ready at the rising edge.
- load_start  in  1  single-cycle restart request.
- fetch_pc  in  64  fetch-stage PC.
- fetch_bytes  out  80  mem[pc+0..pc+9], with byte k at [8k+7:8k].
- fetch_error  out  1  fetch_pc >= MEM_BYTES.
- cpu_hold  out  1  active-high hold/reset to the pipeline.
- load_done  out  1  last load passed its checksum.
- load_err  out  1  last load failed; sticky.
- byte_count  out  9  payload bytes written in the current load.

## Operation
- States: CLEAR, HDR_LO, HDR_HI, DATA, CSUM, RUN, ERR.
- CLEAR: writes 0 to mem[clr_cnt], one byte per cycle, clr_cnt 0..MEM_BYTES-1. After the last byte, go to HDR_LO.
- HDR_LO / HDR_HI: two accepted bytes form length L (16-bit, little-endian).
  - L == 0 or L > MEM_BYTES: go to ERR on the HDR_HI accept.
  - Otherwise go to DATA.
- DATA: each accepted byte does mem[byte_count] <= in_data, byte_count += 1, csum <= csum + in_data (8-bit, mod 256). On the accept where byte_count becomes L, go to CSUM.
- CSUM: on the accepted byte:
  - in_data == csum: go to RUN and set load_done.
  - Mismatch: go to ERR and set load_err.
- RUN: cpu_hold = 0. The block stays here until load_start or reset.
- ERR: cpu_hold = 1. The block stays here until load_start or reset.
- in_ready = 1 only in HDR_LO, HDR_HI, DATA and CSUM.
- cpu_hold = 1 in every state except RUN.
- load_start is honoured in every state except CLEAR:
  - Next state is CLEAR.
  - byte_count, csum, load_done and load_err all go to 0.
  - It takes priority over a same-cycle transfer; that byte is not consumed, since in_ready stays asserted and the transfer does not count.
- load_start during CLEAR is ignored.
- Fetch read path is purely combinational and active in all states.
  - Byte addresses are (fetch_pc + k) mod MEM_BYTES.
  - fetch_error depends only on fetch_pc.
- Memory array is not reset; its contents are defined by the CLEAR pass.

## Timing
- Reset values: state CLEAR, clr_cnt 0, in_ready 0, cpu_hold 1, load_done 0, load_err 0, byte_count 0, csum 0.
- After reset deasserts, CLEAR lasts MEM_BYTES cycles; in_ready first rises in cycle MEM_BYTES (256 by default).
- Each stream byte takes one cycle when in_valid is held high. A load of L bytes therefore takes L+3 accepts.
- cpu_hold falls in the cycle after the edge that accepts a good checksum byte.
- load_done and load_err update on the same edge as the state change.
- A DATA write becomes visible on fetch_bytes in the cycle after its accept edge.
- Reset asserted mid-load: state immediately goes to CLEAR and all outputs take their reset values. The partial program is erased by the following CLEAR pass.

## Structure
- A shared package y86_pkg holds:
  - Loader state enum.
  - Stat codes (SAOK/SHLT/SADR/SINS).
  - Icode constants.
  - MEM_BYTES default.
- One natural sub-module, y86_imem_array:
  - One write port: we, waddr, wdata.
  - A 10-byte wrap-around combinational read window.
- The loader FSM, counters and checksum live in the top module.

## Test plan
- Reset, hold in_valid=0 -> cpu_hold=1 and in_ready=0 for 256 cycles; in_ready=1 in cycle 256; fetch_bytes = 0 for any pc.
- Stream 03 00 10 20 30 60 -> RUN, load_done=1, byte_count=3, cpu_hold=0; fetch_pc=0 gives bytes 10 20 30 00...; fetch_pc=1 gives 20 30 00...
- Stream 02 00 AA BB 00 (bad checksum) -> ERR, load_err=1, cpu_hold=1, in_ready=0.
- Header 00 00, or header 01 01 (257) -> ERR after the second byte.
- Assert load_start mid-DATA with in_valid=1 -> that byte is not written; CLEAR runs 256 cycles; earlier bytes read as 0.
- Full 256-byte load, then fetch_pc=0xFA -> bytes wrap to mem[0..3]; fetch_pc=0x100 -> fetch_error=1.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 definitions.
//   - loader FSM state encoding
//   - processor status codes and instruction icodes
//   - default instruction store size and fetch window width
package y86_pkg;

  localparam int Y86_MEM_BYTES   = 256;
  localparam int Y86_FETCH_BYTES = 10;   // longest Y86 instruction

  typedef enum logic [2:0] {
    LD_CLEAR,
    LD_HDR_LO,
    LD_HDR_HI,
    LD_DATA,
    LD_CSUM,
    LD_RUN,
    LD_ERR
  } ld_state_e;

  // Status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/y86_imem_array.sv
// y86_imem_array: byte-addressed instruction store.
//   CLK          clock
//   we/waddr/wdata  single synchronous write port
//   raddr        window base address
//   rdata        combinational window mem[raddr+0..raddr+WIN-1], addresses
//                wrap modulo MEM_BYTES; byte k at rdata[k]
// Contents are not reset; the owner is expected to initialise them.
module y86_imem_array
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = Y86_MEM_BYTES,
  parameter int ADDR_W    = 8,
  parameter int WIN       = Y86_FETCH_BYTES
) (
  input  logic                    CLK,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [7:0]              wdata,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [WIN-1:0][7:0]     rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar k = 0; k < WIN; k++) begin : g_win
    logic [ADDR_W-1:0] addr;
    // ADDR_W-wide add wraps naturally at the top of the store
    assign addr     = raddr + ADDR_W'(k);
    assign rdata[k] = mem[addr];
  end

endmodule

// File: rtl/y86_imem_loader.sv
// y86_imem_loader: program loader + instruction memory in front of fetch.
//   CLK, reset      clock; asynchronous active-low reset
//   in_data/in_valid/in_ready  program byte stream:
//                   len_lo, len_hi, L payload bytes, 8-bit additive checksum
//   load_start      restart request (ignored while clearing)
//   fetch_pc        fetch PC; fetch_bytes = mem[pc+0..pc+9] (wrapping)
//   fetch_error     fetch_pc outside the store
//   cpu_hold        holds the pipeline in reset except in RUN
//   load_done/load_err  result of the last load
//   byte_count      payload bytes written in the current load
module y86_imem_loader
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = Y86_MEM_BYTES,
  parameter int ADDR_W    = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_start,
  input  logic [63:0] fetch_pc,
  output logic [79:0] fetch_bytes,
  output logic        fetch_error,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [8:0]  byte_count
);

  ld_state_e         state, state_n;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic [8:0]        byte_count_n;
  logic [8:0]        len, len_n;
  logic [7:0]        len_lo, len_lo_n;
  logic [7:0]        csum, csum_n;
  logic              done_n, err_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              xfer;
  logic [15:0]       hdr_len;

  assign xfer    = in_valid && in_ready;
  assign hdr_len = {in_data, len_lo};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= LD_CLEAR;
      clr_cnt    <= '0;
      byte_count <= '0;
      len        <= '0;
      len_lo     <= '0;
      csum       <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      clr_cnt    <= clr_cnt_n;
      byte_count <= byte_count_n;
      len        <= len_n;
      len_lo     <= len_lo_n;
      csum       <= csum_n;
      load_done  <= done_n;
      load_err   <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    clr_cnt_n    = clr_cnt;
    byte_count_n = byte_count;
    len_n        = len;
    len_lo_n     = len_lo;
    csum_n       = csum;
    done_n       = load_done;
    err_n        = load_err;
    we           = 1'b0;
    waddr        = clr_cnt;
    wdata        = 8'h00;
    in_ready     = (state == LD_HDR_LO) || (state == LD_HDR_HI) ||
                   (state == LD_DATA)   || (state == LD_CSUM);
    cpu_hold     = (state != LD_RUN);

    // Restart wins over a same-cycle transfer: the byte is dropped and no
    // write or counter update happens for it.
    if (load_start && state != LD_CLEAR) begin
      state_n      = LD_CLEAR;
      clr_cnt_n    = '0;
      byte_count_n = '0;
      csum_n       = '0;
      done_n       = 1'b0;
      err_n        = 1'b0;
    end else begin
      unique case (state)
        LD_CLEAR: begin
          we        = 1'b1;
          waddr     = clr_cnt;
          wdata     = 8'h00;
          clr_cnt_n = clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(MEM_BYTES - 1)) state_n = LD_HDR_LO;
        end
        LD_HDR_LO: begin
          if (xfer) begin
            len_lo_n = in_data;
            state_n  = LD_HDR_HI;
          end
        end
        LD_HDR_HI: begin
          if (xfer) begin
            if (hdr_len == 16'd0 || hdr_len > 16'(MEM_BYTES)) begin
              state_n = LD_ERR;
              err_n   = 1'b1;
            end else begin
              len_n   = 9'(hdr_len);
              state_n = LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (xfer) begin
            we           = 1'b1;
            waddr        = byte_count[ADDR_W-1:0];
            wdata        = in_data;
            byte_count_n = byte_count + 9'd1;
            csum_n       = csum + in_data;
            if (byte_count + 9'd1 == len) state_n = LD_CSUM;
          end
        end
        LD_CSUM: begin
          if (xfer) begin
            if (in_data == csum) begin
              state_n = LD_RUN;
              done_n  = 1'b1;
            end else begin
              state_n = LD_ERR;
              err_n   = 1'b1;
            end
          end
        end
        LD_RUN, LD_ERR: ;
        default: state_n = LD_CLEAR;
      endcase
    end
  end

  assign fetch_error = (fetch_pc >= 64'(MEM_BYTES));

  y86_imem_array #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W),
    .WIN       (Y86_FETCH_BYTES)
  ) u_mem (
    .CLK   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (fetch_pc[ADDR_W-1:0]),
    .rdata (fetch_bytes)
  );

endmodule
